// File: rtl/ik_swift_iter_ctrl_pkg.sv
// Shared types and constants for the 6-joint IK iteration sequencer.
// Word width, DH row layout and sequencer state encoding.
package ik_swift_pkg;

  localparam int W  = 36;
  localparam int NJ = 6;

  localparam int DH_THETA = 0;
  localparam int DH_D     = 1;
  localparam int DH_A     = 2;
  localparam int DH_ALPHA = 3;

  typedef logic signed [W-1:0] word_t;
  typedef word_t [2:0]         vec3_t;
  typedef word_t [NJ-1:0]      vec6_t;
  typedef word_t [3:0]         dhrow_t;
  typedef dhrow_t [NJ-1:0]     dh_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    UPDATE,
    DONE
  } state_e;

  localparam word_t WMAX = {1'b0, {(W-1){1'b1}}};
  localparam word_t WMIN = {1'b1, {(W-1){1'b0}}};

endpackage

// File: rtl/ik_swift_iter_ctrl_if.sv
// Sequencer <-> DLS datapath bundle.
// master = sequencer side, slave = datapath side.
interface ik_swift_iter_ctrl_if;
  import ik_swift_pkg::*;

  logic       dp_en;
  logic       dp_rst;
  vec3_t      dp_z;
  logic [5:0] dp_joint_type;
  dh_t        dp_dh;
  vec6_t      dp_target;
  vec6_t      dp_delta;

  modport master (
    output dp_en, dp_rst, dp_z, dp_joint_type,
    output dp_dh, dp_target,
    input  dp_delta
  );

  modport slave (
    input  dp_en, dp_rst, dp_z, dp_joint_type,
    input  dp_dh, dp_target,
    output dp_delta
  );

endinterface

// File: rtl/ik_swift_iter_ctrl_sat_add.sv
// One joint: saturating add of delta onto a DH entry plus |delta|<=tol.
// IK_SWIFT_ITER_CTRL_CLAMP_EN adds a symmetric step clamp before the add.
module ik_swift_sat_add
  import ik_swift_pkg::*;
(
  input  word_t a_i,
  input  word_t d_i,
  input  word_t tol_i,
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
  input  word_t max_step_i,
  output logic  clamp_o,
`endif
  output word_t sum_o,
  output logic  ok_o
);

  word_t             step;
  word_t             mag;
  logic signed [W:0] s;

  always_comb begin
    step = d_i;
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
    clamp_o = 1'b0;
    if (d_i > max_step_i) begin
      step    = max_step_i;
      clamp_o = 1'b1;
    end else if (d_i < -max_step_i) begin
      step    = -max_step_i;
      clamp_o = 1'b1;
    end
`endif
    s = (W+1)'(a_i) + (W+1)'(step);
    if (s[W] != s[W-1]) sum_o = s[W] ? WMIN : WMAX;
    else                sum_o = s[W-1:0];
    // convergence looks at the raw delta; the most negative value has no
    // positive twin so it saturates
    if (d_i == WMIN)    mag = WMAX;
    else if (d_i[W-1])  mag = -d_i;
    else                mag = d_i;
    ok_o = (mag <= tol_i);
  end

endmodule

// File: rtl/ik_swift_iter_ctrl.sv
// DLS IK iteration sequencer: run datapath, apply deltas, test convergence.
// IK_SWIFT_ITER_CTRL_CLAMP_EN enables MAX_STEP clamping and clamp_hit.
module ik_swift_iter_ctrl
  import ik_swift_pkg::*;
#(
  parameter int    DP_LATENCY = 64,
  parameter int    MAX_ITER   = 32,
  parameter int    ITER_W     = 6,
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
  parameter word_t MAX_STEP   = 36'sd4096,
`endif
  parameter word_t TOL        = 36'sd16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  vec3_t             z_in,
  input  logic [5:0]        joint_type_in,
  input  dh_t               dh_in,
  input  vec6_t             target_in,
  input  word_t             tol_in,
  ik_swift_iter_ctrl_if.master dp,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count,
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
  output logic              clamp_hit,
`endif
  output dh_t               dh_out
);

  localparam int CW = $clog2(DP_LATENCY + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              conv_q, conv_d;
  vec3_t             z_q, z_d;
  logic [5:0]        jt_q, jt_d;
  dh_t               dh_q, dh_d;
  vec6_t             tgt_q, tgt_d;
  word_t             tol_q, tol_d;
  vec6_t             delta_q, delta_d;
  dh_t               dhout_q, dhout_d;
  logic              en_c, rst_c;
  vec6_t             sum;
  logic [NJ-1:0]     ok;
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
  logic              clamp_q, clamp_d;
  logic [NJ-1:0]     clp;
`endif

  for (genvar j = 0; j < NJ; j++) begin : g_j
    ik_swift_sat_add u_add (
      .a_i        (jt_q[j] ? dh_q[j][DH_D] : dh_q[j][DH_THETA]),
      .d_i        (delta_q[j]),
      .tol_i      (tol_q),
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
      .max_step_i (MAX_STEP),
      .clamp_o    (clp[j]),
`endif
      .sum_o      (sum[j]),
      .ok_o       (ok[j])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    z_d     = z_q;
    jt_d    = jt_q;
    dh_d    = dh_q;
    tgt_d   = tgt_q;
    tol_d   = tol_q;
    delta_d = delta_q;
    dhout_d = dhout_q;
    en_c    = 1'b0;
    rst_c   = 1'b0;
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
    clamp_d = clamp_q;
`endif
    unique case (state_q)
      IDLE: begin
        rst_c = 1'b1;
        if (start) begin
          z_d     = z_in;
          jt_d    = joint_type_in;
          dh_d    = dh_in;
          tgt_d   = target_in;
          tol_d   = (tol_in == '0) ? TOL : tol_in;
          iter_d  = '0;
          conv_d  = 1'b0;
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
          clamp_d = 1'b0;
`endif
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        rst_c   = 1'b1;
        cnt_d   = CW'(DP_LATENCY - 1);
        state_d = RUN;
      end
      RUN: begin
        en_c = 1'b1;
        if (cnt_q == '0) begin
          delta_d = dp.dp_delta;
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      UPDATE: begin
        for (int j = 0; j < NJ; j++) begin
          if (jt_q[j]) dh_d[j][DH_D]     = sum[j];
          else         dh_d[j][DH_THETA] = sum[j];
        end
        iter_d = iter_q + ITER_W'(1);
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
        clamp_d = clamp_q | (|clp);
`endif
        // convergence wins over the cap when both land together
        if (&ok) begin
          conv_d  = 1'b1;
          dhout_d = dh_d;
          state_d = DONE;
        end else if (iter_d == ITER_W'(MAX_ITER)) begin
          dhout_d = dh_d;
          state_d = DONE;
        end else begin
          state_d = CLEAR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      z_q     <= '0;
      jt_q    <= '0;
      dh_q    <= '0;
      tgt_q   <= '0;
      tol_q   <= '0;
      delta_q <= '0;
      dhout_q <= '0;
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
      clamp_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
      z_q     <= z_d;
      jt_q    <= jt_d;
      dh_q    <= dh_d;
      tgt_q   <= tgt_d;
      tol_q   <= tol_d;
      delta_q <= delta_d;
      dhout_q <= dhout_d;
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
      clamp_q <= clamp_d;
`endif
    end
  end

  assign dp.dp_en         = en_c;
  assign dp.dp_rst        = rst_c;
  assign dp.dp_z          = z_q;
  assign dp.dp_joint_type = jt_q;
  assign dp.dp_dh         = dh_q;
  assign dp.dp_target     = tgt_q;

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign converged  = conv_q;
  assign iter_count = iter_q;
  assign dh_out     = dhout_q;
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
  assign clamp_hit  = clamp_q;
`endif

endmodule

// File: tb/tb_ik_swift_iter_ctrl.sv
// Directed bench for ik_swift_iter_ctrl with a behavioural datapath model.
// Expected job results are queued at start and popped on done.
module tb_ik_swift_iter_ctrl;
  import ik_swift_pkg::*;

  localparam int LAT = 4;
  localparam int MI  = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  vec3_t      z_in;
  logic [5:0] jt_in;
  dh_t        dh_in;
  vec6_t      tgt_in;
  word_t      tol_in;
  logic       busy, done, converged;
  logic [5:0] iter_count;
  dh_t        dh_out;
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
  logic       clamp_hit;
`endif

  ik_swift_iter_ctrl_if dif ();

  ik_swift_iter_ctrl #(
    .DP_LATENCY (LAT),
    .MAX_ITER   (MI),
    .ITER_W     (6),
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
    .MAX_STEP   (36'sd4096),
`endif
    .TOL        (36'sd16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .z_in          (z_in),
    .joint_type_in (jt_in),
    .dh_in         (dh_in),
    .target_in     (tgt_in),
    .tol_in        (tol_in),
    .dp            (dif.master),
    .busy          (busy),
    .done          (done),
    .converged     (converged),
    .iter_count    (iter_count),
`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
    .clamp_hit     (clamp_hit),
`endif
    .dh_out        (dh_out)
  );

  always #5 clk = ~clk;

  int    mode = 0;
  int    mi;
  logic  en_d;
  vec6_t mdelta;

  // datapath model: mi counts finished dp_en bursts within a job
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mi   <= 0;
      en_d <= 1'b0;
    end else begin
      en_d <= dif.dp_en;
      if (!busy)                    mi <= 0;
      else if (en_d && !dif.dp_en)  mi <= mi + 1;
    end
  end

  always_comb begin
    mdelta = '0;
    case (mode)
      1: if (mi < 2) for (int j = 0; j < NJ; j++) mdelta[j] = 36'sd100;
      2: mdelta[0] = 36'sd17;
      3: mdelta[0] = 36'sd16;
      4: if (mi < 1) mdelta[0] = 36'sd100;
      5: if (mi < 1) mdelta[0] = WMIN;
      6: if (mi < 1) mdelta[0] = 36'sd10000;
      default: ;
    endcase
  end

  assign dif.dp_delta = mdelta;

  typedef struct packed {
    logic       conv;
    logic [5:0] iter;
    dh_t        dh;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dh(input string tag, input dh_t obs, input dh_t exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string tag, input dh_t d,
                         input logic [5:0] jt, input word_t tol,
                         input exp_t e, input bit poke,
                         output int lat, output int en_cnt);
    bit   got;
    exp_t x;
    @(negedge clk);
    dh_in  = d;
    jt_in  = jt;
    tol_in = tol;
    start  = 1'b1;
    sb.push_back(e);
    got    = 1'b0;
    lat    = 0;
    en_cnt = 0;
    for (int c = 1; c <= 3000 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && c == 3) begin
        start = 1'b1;
        dh_in = '0;
        jt_in = '1;
      end
      if (dif.dp_en) en_cnt++;
      if (done) begin
        got = 1'b1;
        lat = c;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 64'(got), 64'(1));
    x = sb.pop_front();
    if (got) begin
      chk({tag, "_conv"}, 64'(converged), 64'(x.conv));
      chk({tag, "_iter"}, 64'(iter_count), 64'(x.iter));
      chk_dh({tag, "_dh_out"}, dh_out, x.dh);
      @(negedge clk);
      chk({tag, "_busy_fall"}, 64'(busy), 64'(0));
      chk({tag, "_done_1cyc"}, 64'(done), 64'(0));
    end
  endtask

  initial begin
    dh_t  dh0, d, ex;
    exp_t e;
    int   lat, enc, nd;
    bit   hit;

    z_in   = '{36'sd0, 36'sd0, 36'sd1};
    tgt_in = '{36'sd6, 36'sd5, 36'sd4, 36'sd3, 36'sd2, 36'sd1};
    jt_in  = '0;
    dh_in  = '0;
    tol_in = '0;
    for (int j = 0; j < NJ; j++)
      for (int i = 0; i < 4; i++)
        dh0[j][i] = word_t'(j * 16 + i + 1);

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dp_en", 64'(dif.dp_en), 64'(0));
    chk("rst_dp_rst", 64'(dif.dp_rst), 64'(1));
    chk("rst_iter", 64'(iter_count), 64'(0));
    chk("rst_conv", 64'(converged), 64'(0));
    chk_dh("rst_dh_out", dh_out, '0);
    rst = 1'b0;

    // zero delta: one iteration, fixed latency
    mode = 0;
    e.conv = 1'b1; e.iter = 6'd1; e.dh = dh0;
    run_job("zero", dh0, 6'b000000, '0, e, 1'b0, lat, enc);
    chk("zero_latency", 64'(lat), 64'(7));
    chk("zero_en_cycles", 64'(enc), 64'(LAT));
    chk("dp_z_latched", 64'(dif.dp_z[0]), 64'(36'sd1));
    chk("dp_tgt_latched", 64'(dif.dp_target[5]), 64'(36'sd6));

    // mixed joint types, start poked while busy
    mode = 1;
    ex = dh0;
    for (int j = 0; j < NJ; j++) begin
      if (j == 1) ex[j][DH_D]     = dh0[j][DH_D] + 36'sd200;
      else        ex[j][DH_THETA] = dh0[j][DH_THETA] + 36'sd200;
    end
    e.conv = 1'b1; e.iter = 6'd3; e.dh = ex;
    run_job("mixed", dh0, 6'b000010, '0, e, 1'b1, lat, enc);

    // delta 17 > default tol 16: hits the cap
    mode = 2;
    ex = dh0;
    ex[0][DH_THETA] = dh0[0][DH_THETA] + 36'sd544;
    e.conv = 1'b0; e.iter = 6'd32; e.dh = ex;
    run_job("cap", dh0, 6'b000000, '0, e, 1'b0, lat, enc);

    // runtime tol 17 accepts delta 17
    ex = dh0;
    ex[0][DH_THETA] = dh0[0][DH_THETA] + 36'sd17;
    e.conv = 1'b1; e.iter = 6'd1; e.dh = ex;
    run_job("rt_tol", dh0, 6'b000000, 36'sd17, e, 1'b0, lat, enc);

    // delta exactly at tol converges
    mode = 3;
    ex = dh0;
    ex[0][DH_THETA] = dh0[0][DH_THETA] + 36'sd16;
    e.conv = 1'b1; e.iter = 6'd1; e.dh = ex;
    run_job("at_tol", dh0, 6'b000000, '0, e, 1'b0, lat, enc);

    // positive saturation
    mode = 4;
    d = dh0;
    d[0][DH_THETA] = WMAX - 36'sd9;
    ex = d;
    ex[0][DH_THETA] = WMAX;
    e.conv = 1'b1; e.iter = 6'd2; e.dh = ex;
    run_job("sat_pos", d, 6'b000000, '0, e, 1'b0, lat, enc);

    // most negative delta: not converged, negative saturation
    mode = 5;
    d = dh0;
    d[0][DH_THETA] = -36'sd5;
    ex = d;
    ex[0][DH_THETA] = WMIN;
    e.conv = 1'b1; e.iter = 6'd2; e.dh = ex;
    run_job("min_delta", d, 6'b000000, '0, e, 1'b0, lat, enc);

`ifdef IK_SWIFT_ITER_CTRL_CLAMP_EN
    mode = 6;
    ex = dh0;
    ex[0][DH_THETA] = dh0[0][DH_THETA] + 36'sd4096;
    e.conv = 1'b1; e.iter = 6'd2; e.dh = ex;
    run_job("clamp", dh0, 6'b000000, '0, e, 1'b1, lat, enc);
    chk("clamp_hit", 64'(clamp_hit), 64'(1));
`endif

    // reset during the third iteration
    mode = 2;
    @(negedge clk);
    dh_in = dh0;
    jt_in = '0;
    tol_in = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      if (mi == 2 && dif.dp_en) hit = 1'b1;
      else @(negedge clk);
    end
    chk("rst_mid_reached", 64'(hit), 64'(1));
    chk("iter_before_rst", 64'(iter_count), 64'(2));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_dp_en", 64'(dif.dp_en), 64'(0));
    chk("mid_rst_dp_rst", 64'(dif.dp_rst), 64'(1));
    chk("mid_rst_iter", 64'(iter_count), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_rst_no_done", 64'(nd), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ik_swift_iter_ctrl.md
Name: ik_swift_iter_ctrl

Overview:
Iteration sequencer for the 6-joint damped-least-squares IK datapath. Latches a job (base axis z, joint_type, initial DH parameters, target) on start and drives the datapath's en/rst. Waits the datapath latency, then applies the returned delta vector to the joint-variable DH entries. Repeats until every |delta| is at or below a tolerance, or an iteration cap is hit.

Parameters:
W, 36, datapath word width (signed two's complement, all values)
DP_LATENCY, 64, cycles from dp_en rise to dp_delta valid (>=1)
MAX_ITER, 32, iteration cap (>=1)
ITER_W, 6, width of iteration counter (holds MAX_ITER)
TOL, 36'sd16, convergence threshold on |delta_i| (>=0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle job request; honoured only in IDLE
z_in  in  3xW  base joint axis
joint_type_in  in  6  per-joint type, 1=prismatic, 0=revolute
dh_in  in  6x4xW  initial DH params [j][0]=theta,[1]=d,[2]=a,[3]=alpha
target_in  in  6xW  target pose
tol_in  in  W  runtime tolerance; 0 selects TOL
dp_en  out  1  datapath enable
dp_rst  out  1  datapath synchronous clear
dp_z  out  3xW  latched z to datapath
dp_joint_type  out  6  latched joint_type to datapath
dp_dh  out  6x4xW  current DH params to datapath
dp_target  out  6xW  latched target to datapath
dp_delta  in  6xW  joint deltas from datapath
busy  out  1  high from start acceptance until DONE
done  out  1  one-cycle pulse on job completion
converged  out  1  valid with done, held until next start
iter_count  out  ITER_W  iterations completed in current/last job
dh_out  out  6x4xW  final DH params, held until next start

Behaviour:
- Reset: state=IDLE. dp_en=0, dp_rst=1, busy=0, done=0, converged=0, iter_count=0, all latched vectors and dh_out=0.
- IDLE: dp_rst=1, dp_en=0. On start=1, latch z/joint_type/dh/target and effective tol, clear iter_count and converged -> CLEAR. start outside IDLE is ignored.
- CLEAR (1 cycle): dp_rst=1 -> RUN, and load wait counter with DP_LATENCY-1.
- RUN: dp_rst=0, dp_en=1, dp_dh stable. Counter decrements each cycle. When counter reaches 0 -> UPDATE, sampling dp_delta that cycle. Total dp_en-high cycles per iteration = DP_LATENCY.
- UPDATE (1 cycle): dp_en=0. For each joint j, if joint_type[j], d_j += delta_j, else theta_j += delta_j. Sum is saturating to [-2^(W-1), 2^(W-1)-1]. a/alpha never change. iter_count += 1. Convergence flag = AND over j of |delta_j| <= tol, where |-2^(W-1)| saturates to 2^(W-1)-1. The flag uses the unclamped delta.
- UPDATE exit: if flag -> DONE with converged=1. Else if iter_count (post-increment) == MAX_ITER -> DONE with converged=0. Else -> CLEAR.
- DONE (1 cycle): done=1, dh_out <= dp_dh, busy falls next cycle -> IDLE.
- busy=1 in CLEAR, RUN, UPDATE and DONE.
- If convergence and the cap occur in the same iteration, converged=1.
- rst mid-job aborts immediately to reset values. No done pulse is produced.
- delta=0 on the first iteration converges with iter_count=1.

Optional Feature:
IK_SWIFT_ITER_CTRL_CLAMP_EN
- Defined: adds parameter MAX_STEP (default 36'sd4096). Each delta_j is clamped to [-MAX_STEP, MAX_STEP] before the UPDATE add. Adds output clamp_hit (1 bit), set if any delta was clamped in the job, cleared on start.
- Undefined: raw deltas are added, and neither MAX_STEP nor clamp_hit exists.

Decomposition:
- Package ik_swift_pkg: W, joint count 6, DH index constants (DH_THETA=0, DH_D=1, DH_A=2, DH_ALPHA=3), the packed types word_t, vec6_t, dh_t, and the state enum {IDLE, CLEAR, RUN, UPDATE, DONE}.
- Sub-module ik_swift_sat_add: one W-bit saturating add plus abs/compare, instantiated 6x.

Test Plan:
- Reset mid-RUN (iter 3) -> next cycle busy=0, dp_en=0, dp_rst=1, iter_count=0, no done pulse.
- DP_LATENCY=4, model returns delta all 0 -> dp_en high exactly 4 cycles; done pulses 7 cycles after start (CLEAR+4 RUN+UPDATE+DONE); converged=1, iter_count=1, dh_out==dh_in.
- joint_type=6'b000010, model delta_j=100 each iteration for 2 iterations then 0 -> joint1 d +=200, other joints theta +=200, a/alpha unchanged, iter_count=3, converged=1.
- Model delta_0 constant 17, TOL=16, MAX_ITER=32 -> done with converged=0, iter_count=32. Model delta_0=16 -> converged on iter 1.
- theta_0 = 2^35-10, delta_0=+100 -> theta_0 = 2^35-1 (saturated). delta=-2^35 is treated as not converged.
- With CLAMP_EN, MAX_STEP=4096, delta_0=10000 -> theta_0 increases by 4096, clamp_hit=1. start asserted while busy -> ignored, job unaffected.
